// File: rtl/segled_pkg.sv
// segled_pkg: shared definitions for the seven-segment scan decoder.
//   - SEG_GLYPH_0..SEG_GLYPH_F : active-low glyph patterns, bit order g..a
//   - SEG_BLANK                : all segments off
//   - seg_state_t              : scan-capture FSM states
package segled_pkg;

  localparam logic [6:0] SEG_GLYPH_0 = 7'b1000000;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1111001;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0110000;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b0011001;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0000010;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b1111000;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0010000;
  localparam logic [6:0] SEG_GLYPH_A = 7'b0001000;
  localparam logic [6:0] SEG_GLYPH_B = 7'b0000011;
  localparam logic [6:0] SEG_GLYPH_C = 7'b1000110;
  localparam logic [6:0] SEG_GLYPH_D = 7'b0100001;
  localparam logic [6:0] SEG_GLYPH_E = 7'b0000110;
  localparam logic [6:0] SEG_GLYPH_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HELD  = 2'd2
  } seg_state_t;

endpackage

// File: rtl/segpat_decode.sv
// segpat_decode: combinational seven-segment pattern to hex nibble lookup.
// Ports:
//   pattern : in  7  active-low segments, bit0=a .. bit6=g
//   nibble  : out 4  decoded hex value (0 when no glyph matches)
//   hit     : out 1  pattern is one of the 16 hex glyphs
module segpat_decode
  import segled_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (pattern)
      SEG_GLYPH_0: nibble = 4'h0;
      SEG_GLYPH_1: nibble = 4'h1;
      SEG_GLYPH_2: nibble = 4'h2;
      SEG_GLYPH_3: nibble = 4'h3;
      SEG_GLYPH_4: nibble = 4'h4;
      SEG_GLYPH_5: nibble = 4'h5;
      SEG_GLYPH_6: nibble = 4'h6;
      SEG_GLYPH_7: nibble = 4'h7;
      SEG_GLYPH_8: nibble = 4'h8;
      SEG_GLYPH_9: nibble = 4'h9;
      SEG_GLYPH_A: nibble = 4'hA;
      SEG_GLYPH_B: nibble = 4'hB;
      SEG_GLYPH_C: nibble = 4'hC;
      SEG_GLYPH_D: nibble = 4'hD;
      SEG_GLYPH_E: nibble = 4'hE;
      SEG_GLYPH_F: nibble = 4'hF;
      default:     hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/segled_scan_decoder.sv
// segled_scan_decoder: receive side of a multiplexed seven-segment bus.
// Samples active-low segment and digit-select lines, waits for a pattern to
// stay stable for STABLE_CYCLES samples within one digit dwell, then decodes
// it into the nibble slot of the selected digit (exactly once per dwell).
//
// Optional build macro SEGDEC_DP_EN: seg_n grows to 8 bits (bit7 = decimal
// point, active low) and output dp reports the lit decimal point per digit.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   seg_n        : in  7 (8)  segments, active low, bit0=a .. bit6=g (bit7=dp)
//   dig_n        : in  NDIG   digit selects, active low, one-hot-low = scan slot
//   value        : out 4*NDIG decoded nibbles, digit i at [4i+3:4i]
//   digit_valid  : out NDIG   last capture of digit i decoded successfully
//   upd          : out 1      one-cycle pulse on a successful capture
//   upd_idx      : out 3      digit index of the latest capture (upd/err)
//   err          : out 1      one-cycle pulse when a stable pattern is no glyph
//   dp           : out NDIG   decimal point lit (SEGDEC_DP_EN only)
//   dbg_state    : out        current capture FSM state, for observation
module segled_scan_decoder
  import segled_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SEGDEC_DP_EN
  input  logic [7:0]          seg_n,
`else
  input  logic [6:0]          seg_n,
`endif
  input  logic [NDIG-1:0]     dig_n,
  output logic [4*NDIG-1:0]   value,
  output logic [NDIG-1:0]     digit_valid,
  output logic                upd,
  output logic [2:0]          upd_idx,
  output logic                err,
`ifdef SEGDEC_DP_EN
  output logic [NDIG-1:0]     dp,
`endif
  output seg_state_t          dbg_state
);

`ifdef SEGDEC_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  // Input stage (seg_q/dig_q) plus one-cycle history (seg_p/dig_p) used to
  // decide whether the current sample repeats the previous one.
  logic [SEG_W-1:0] seg_q, seg_p;
  logic [NDIG-1:0]  dig_q, dig_p;

  seg_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             capture;

  logic [3:0]       zeros;
  logic [2:0]       cur_idx;
  logic             onehot;
  logic             same;

  logic [3:0]       dec_nib;
  logic             dec_hit;

  segpat_decode u_dec (
    .pattern (seg_q[6:0]),
    .nibble  (dec_nib),
    .hit     (dec_hit)
  );

  // Count low selects; cur_idx is only meaningful when exactly one is low.
  always_comb begin
    zeros   = 4'd0;
    cur_idx = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!dig_q[i]) begin
        zeros   = zeros + 4'd1;
        cur_idx = 3'(i);
      end
    end
    onehot = (zeros == 4'd1);
  end

  // The DP bit (when present) is part of seg_q, so it takes part in the
  // stability comparison even though the decoder ignores it.
  assign same = (seg_q == seg_p) && (dig_q == dig_p);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!onehot) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          // Coming out of blanking/overlap the sample always differs from
          // the previous one, so this is the first sample of the dwell.
          state_n = COUNT;
          cnt_n   = CNT_W'(1);
        end
        COUNT: begin
          if (!same) begin
            cnt_n = CNT_W'(1);
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            capture = 1'b1;
            state_n = HELD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!same) begin
            state_n = COUNT;
            cnt_n   = CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '1;
      seg_p       <= '1;
      dig_q       <= '1;
      dig_p       <= '1;
      value       <= '0;
      digit_valid <= '0;
      upd         <= 1'b0;
      err         <= 1'b0;
      upd_idx     <= 3'd0;
`ifdef SEGDEC_DP_EN
      dp          <= '0;
`endif
    end else begin
      seg_q <= seg_n;
      seg_p <= seg_q;
      dig_q <= dig_n;
      dig_p <= dig_q;
      upd   <= 1'b0;
      err   <= 1'b0;
      if (capture) begin
        upd_idx <= cur_idx;
        upd     <= dec_hit;
        err     <= !dec_hit;
        for (int i = 0; i < NDIG; i++) begin
          if (cur_idx == 3'(i)) begin
            digit_valid[i] <= dec_hit;
            if (dec_hit) begin
              value[4*i +: 4] <= dec_nib;
`ifdef SEGDEC_DP_EN
              dp[i] <= !seg_q[7];
`endif
            end
          end
        end
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_segled_scan_decoder.sv
// Directed bench for segled_scan_decoder (default parameters).
module tb_segled_scan_decoder;
  import segled_pkg::*;

  localparam int NDIG = 4;
`ifdef SEGDEC_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  // Hand-written glyph patterns (g..a, active low).
  localparam logic [6:0] P_0 = 7'b1000000;
  localparam logic [6:0] P_1 = 7'b1111001;
  localparam logic [6:0] P_2 = 7'b0100100;
  localparam logic [6:0] P_7 = 7'b1111000;
  localparam logic [6:0] P_8 = 7'b0000000;
  localparam logic [6:0] P_A = 7'b0001000;
  localparam logic [6:0] P_C = 7'b1000110;
  localparam logic [6:0] P_D = 7'b0100001;
  localparam logic [6:0] P_E = 7'b0000110;
  localparam logic [6:0] P_OFF = 7'b1111111;

  logic              clk;
  logic              rst;
  logic [SEG_W-1:0]  seg_n;
  logic [NDIG-1:0]   dig_n;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   digit_valid;
  logic              upd;
  logic [2:0]        upd_idx;
  logic              err;
`ifdef SEGDEC_DP_EN
  logic [NDIG-1:0]   dp;
`endif
  seg_state_t        dbg_state;

  segled_scan_decoder #(
    .NDIG          (NDIG),
    .STABLE_CYCLES (16),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .value       (value),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .err         (err),
`ifdef SEGDEC_DP_EN
    .dp          (dp),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state: expected upd events as {idx[2:0], nibble[3:0]}.
  logic [6:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int tcnt, n_upd, n_err, first_upd;
  logic [2:0] err_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic [NDIG-1:0] dig, input logic [6:0] pat);
    dig_n = dig;
    seg_n = '1;
    seg_n[6:0] = pat;
  endtask

  task automatic phase_start();
    tcnt      = 0;
    n_upd     = 0;
    n_err     = 0;
    first_upd = 0;
  endtask

  // One clock; outputs observed 1 time unit after the rising edge.
  task automatic tick();
    logic [15:0] sh;
    @(posedge clk);
    #1;
    tcnt++;
    if (upd || err) chk("upd_err_excl", {31'd0, upd & err}, 32'd0);
    if (upd) begin
      n_upd++;
      if (first_upd == 0) first_upd = tcnt;
      sh = value >> (4 * upd_idx);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_upd: got idx %0d want no update", upd_idx);
      end
      if (exp_q.size() != 0) chk("sb_upd", {25'd0, upd_idx, sh[3:0]}, {25'd0, exp_q.pop_front()});
    end
    if (err) begin
      n_err++;
      err_idx = upd_idx;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  logic [NDIG-1:0] scan_dig [4];
  logic [6:0]      scan_pat [4];
  logic [6:0]      scan_exp [4];

  initial begin
    scan_dig = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    scan_pat = '{P_C, P_0, P_D, P_E};
    scan_exp = '{{3'd3, 4'hC}, {3'd2, 4'h0}, {3'd1, 4'hD}, {3'd0, 4'hE}};

    // Reset
    rst = 1'b1;
    drive(4'b1111, SEG_BLANK);
    phase_start();
    run(3);
    rst = 1'b0;
    chk("rst_value", {16'd0, value}, 32'd0);
    chk("rst_valid", {28'd0, digit_valid}, 32'd0);
    chk("rst_upd", {31'd0, upd}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_idx", {29'd0, upd_idx}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Single digit 0 showing "2": upd on the 17th edge after the pins settle
    phase_start();
    drive(4'b1110, P_2);
    exp_q.push_back({3'd0, 4'h2});
    run(20);
    chk("t1_nupd", n_upd, 1);
    chk("t1_lat", first_upd, 17);
    chk("t1_nerr", n_err, 0);
    chk("t1_value", {16'd0, value}, 32'h0002);
    chk("t1_valid", {28'd0, digit_valid}, 32'b0001);
    chk("t1_held", {30'd0, dbg_state}, {30'd0, HELD});

    // Full frame "C0dE" with blanking between dwells
    phase_start();
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, P_OFF);
      run(2);
      drive(scan_dig[i], scan_pat[i]);
      exp_q.push_back(scan_exp[i]);
      run(32);
    end
    chk("t2_nupd", n_upd, 4);
    chk("t2_nerr", n_err, 0);
    chk("t2_value", {16'd0, value}, 32'hC0DE);
    chk("t2_valid", {28'd0, digit_valid}, 32'b1111);
    chk("t2_drain", exp_q.size(), 0);

    // Blank digit 1: single err, slot value untouched, valid bit cleared
    phase_start();
    drive(4'b1111, P_OFF);
    run(2);
    drive(4'b1101, P_OFF);
    run(20);
    chk("t3_nerr", n_err, 1);
    chk("t3_nupd", n_upd, 0);
    chk("t3_erridx", {29'd0, err_idx}, 32'd1);
    chk("t3_valid", {28'd0, digit_valid}, 32'b1101);
    chk("t3_value", {16'd0, value}, 32'hC0DE);

    // Glitch 7 -> 1 -> 7 on digit 2: count restarts after the glitch
    drive(4'b1111, P_OFF);
    run(2);
    phase_start();
    drive(4'b1011, P_7);
    run(8);
    drive(4'b1011, P_1);
    run(1);
    drive(4'b1011, P_7);
    exp_q.push_back({3'd2, 4'h7});
    run(15);
    chk("t4_noearly", n_upd, 0);
    run(5);
    chk("t4_nupd", n_upd, 1);
    chk("t4_lat", first_upd, 26);
    chk("t4_nerr", n_err, 0);
    chk("t4_value", {16'd0, value}, 32'hC7DE);
    chk("t4_valid", {28'd0, digit_valid}, 32'b1101);

    // Overlapping selects: nothing captured, outputs retained
    phase_start();
    drive(4'b1100, P_8);
    run(40);
    chk("t5_nupd", n_upd, 0);
    chk("t5_nerr", n_err, 0);
    chk("t5_value", {16'd0, value}, 32'hC7DE);
    chk("t5_valid", {28'd0, digit_valid}, 32'b1101);
    chk("t5_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // Reset in the middle of a dwell, dwell continues afterwards
    phase_start();
    drive(4'b1111, P_OFF);
    run(2);
    drive(4'b0111, P_A);
    run(10);
    chk("t6_prerst", n_upd, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_value", {16'd0, value}, 32'd0);
    chk("t6_rst_valid", {28'd0, digit_valid}, 32'd0);
    phase_start();
    exp_q.push_back({3'd3, 4'hA});
    run(20);
    chk("t6_nupd", n_upd, 1);
    chk("t6_lat", first_upd, 17);
    chk("t6_nerr", n_err, 0);
    chk("t6_value", {16'd0, value}, 32'hA000);
    chk("t6_valid", {28'd0, digit_valid}, 32'b1000);
    chk("t6_drain", exp_q.size(), 0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segled_scan_decoder.md
Name: segled_scan_decoder

Overview:
- Receive end of the team's multiplexed seven-segment display interface: samples active-low segment lines and active-low digit selects, then reconstructs the hex nibble shown on each digit.
- Used on the demo board to read back display content for self-check, and to bridge to external boards that drive a 7-seg bus.
- Filters scan transitions and ghosting with a per-dwell stability counter.
- Flags patterns that are not one of the 16 hex glyphs.

Parameters:
- NDIG, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 16, consecutive identical samples required before capture (2..65535).
- CNT_W, 16, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- seg_n  in  7  segment lines, active low; bit0=a … bit6=g.
- dig_n  in  NDIG  digit selects, active low; a valid scan slot has exactly one bit low.
- value  out  4*NDIG  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  out  NDIG  bit i set when digit i's last capture decoded successfully.
- upd  out  1  one-cycle pulse when a capture succeeds.
- upd_idx  out  3  index of the captured digit; meaningful only while upd or err is high.
- err  out  1  one-cycle pulse when a stable pattern matches no glyph.

Behaviour:
- Glyph table (active low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Inputs are registered once (1-cycle input stage). All decisions below use the registered copies seg_q and dig_q.
- States:
  - IDLE: dig_q is not one-hot-low, i.e. none or several digits selected (blanking or overlap). The counter is held at 0.
  - COUNT: one-hot dig_q. Each cycle, if seg_q and dig_q equal the previous cycle's values, cnt increments; otherwise cnt reloads to 1. When cnt reaches STABLE_CYCLES-1 with a matching sample, a capture fires and the FSM goes to HELD.
  - HELD: capture is already done for this dwell. Any change in seg_q or dig_q returns the FSM to COUNT with cnt=1, or to IDLE if dig_q is not one-hot.
  - This guarantees exactly one capture per stable dwell.
- Capture result:
  - On a glyph hit: value slot ← nibble, digit_valid[i] ← 1, upd=1.
  - On a miss: value slot unchanged, digit_valid[i] ← 0, err=1.
  - upd and err are mutually exclusive and each lasts one cycle.
  - Latency from a new stable input at the pins to the upd pulse is STABLE_CYCLES+1 cycles.
- IDLE from any state clears cnt but never alters value or digit_valid.
- Reset: on rst=1 at a clock edge, the FSM goes to IDLE and cnt=0.
  - value=0, digit_valid=0, upd=0, err=0, upd_idx=0.
  - Input registers reset to all-ones (blank, nothing selected).
  - Reset mid-dwell discards the partial count.
- Boundary cases:
  - A digit index ≥ NDIG cannot occur, because dig_n width equals NDIG.
  - All segments off (1111111) is a miss and raises err. Blank digits therefore read as invalid.
  - Counter saturation cannot occur because the HELD state stops counting.

Optional Feature:
- SEGDEC_DP_EN defined:
  - seg_n becomes 8 bits, with bit7 = decimal point, active low.
  - Adds output dp, NDIG bits, updated on successful captures only.
  - The DP bit is excluded from glyph matching but included in the stability comparison.
- Undefined:
  - seg_n is 7 bits and dp does not exist.

Decomposition:
- Package segled_pkg holds:
  - the 16 glyph constants SEG_GLYPH_0..F (7-bit, active low);
  - the state enum {IDLE, COUNT, HELD};
  - SEG_BLANK=7'h7F.
- Sub-module segpat_decode is purely combinational: input 7-bit pattern; outputs 4-bit nibble and 1-bit hit. It is reused by the future loopback checker.

Test Plan:
- Reset, then hold dig_n=1110, seg_n=0100100 for 20 cycles → exactly one upd with upd_idx=0 at cycle 17 after the pins settle; value[3:0]=2; digit_valid=0001.
- Scan 4 digits showing "C0dE" (dig3..dig0 = C,0,d,E), dwell 32 cycles each with 2 blank cycles between → after one frame value=16'hC0DE, digit_valid=1111, 4 upd pulses, no err.
- dig_n=1101 with seg_n=1111111 for 20 cycles → single err pulse with upd_idx=1; digit_valid[1] cleared; value[7:4] unchanged.
- Segment glitch at cycle 8 of a 16-cycle window (dig_n=1011, 7 then 1 then 7) → no capture until 16 clean cycles after the glitch; then value[11:8]=7.
- Overlap dig_n=1100 for 40 cycles → no upd or err; outputs retain prior values.
- rst asserted at cycle 10 of a dwell, released, dwell continues → no capture until a full STABLE_CYCLES after release; value=0 immediately after reset.
